// File: rtl/prioritised_stream_pkg.sv
// +----------------------------------------------------------------------------+
// | prioritised_stream_pkg: shared state, class and sizing definitions          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package prioritised_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IN_HP = 2'd1,
    IN_LP = 2'd2
  } state_e;

  localparam logic CLASS_HP = 1'b1;
  localparam logic CLASS_LP = 1'b0;

  // Fill counters need one extra bit so that a completely full FIFO is representable.
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_class_fifo.sv
// +----------------------------------------------------------------------------+
// | stream_class_fifo: first-word-fall-through FIFO of {tlast, data} beats      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_class_fifo
  import prioritised_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push_i,
  input  logic [DATA_WIDTH-1:0]               data_i,
  input  logic                                tlast_i,
  input  logic                                pop_i,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                tlast_o,
  output logic                                valid_o,
  output logic                                full_o,
  output logic [fill_width(FIFO_DEPTH)-1:0]   fill_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = fill_width(FIFO_DEPTH);

  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [FILL_W-1:0]   fill_q;
  logic                w_push;
  logic                w_pop;

  assign full_o  = (fill_q == FILL_W'(FIFO_DEPTH));
  assign valid_o = reset && (fill_q != '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && valid_o;
  assign fill_o  = fill_q;

  // Outputs read zero whenever nothing is held, including throughout reset.
  assign {tlast_o, data_o} = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wr_ptr_q] <= {tlast_i, data_i};
  end

endmodule

`default_nettype wire

// File: rtl/priority_stream_splitter.sv
// +----------------------------------------------------------------------------+
// | priority_stream_splitter: routes whole packets into independent HP/LP FIFOs |
// | Option macro: PRIORITY_STREAM_SPLITTER_DROP_EN (drop instead of stall)      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module priority_stream_splitter
  import prioritised_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              data_in_valid,
  input  logic                              data_in_tlast,
  input  logic                              data_in_prio,
  output logic                              data_in_ready,
  output logic [DATA_WIDTH-1:0]             data_out_hp,
  output logic                              data_out_hp_valid,
  output logic                              data_out_hp_tlast,
  input  logic                              data_out_hp_ready,
  output logic [DATA_WIDTH-1:0]             data_out_lp,
  output logic                              data_out_lp_valid,
  output logic                              data_out_lp_tlast,
  input  logic                              data_out_lp_ready,
  output logic [fill_width(FIFO_DEPTH)-1:0] hp_fill_level,
  output logic [fill_width(FIFO_DEPTH)-1:0] lp_fill_level
`ifdef PRIORITY_STREAM_SPLITTER_DROP_EN
  ,
  output logic [15:0]                       drop_count
`endif
);

  state_e state_q, state_d;
  logic   target_class;
  logic   target_full;
  logic   hp_full, lp_full;
  logic   accept;
  logic   store;

  always_comb begin
    unique case (state_q)
      IN_HP:   target_class = CLASS_HP;
      IN_LP:   target_class = CLASS_LP;
      default: target_class = data_in_prio;
    endcase
  end

  assign target_full = (target_class == CLASS_HP) ? hp_full : lp_full;

`ifdef PRIORITY_STREAM_SPLITTER_DROP_EN
  logic [15:0] drop_count_q;
  logic        drop;

  assign data_in_ready = 1'b1;
  assign store         = data_in_valid && !target_full;
  assign drop          = data_in_valid && target_full;
  assign drop_count    = drop_count_q;

  always_ff @(posedge clock) begin
    if (!reset)                               drop_count_q <= '0;
    else if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
  end
`else
  assign data_in_ready = !target_full;
  assign store         = data_in_valid && data_in_ready;
`endif

  // Dropped beats still count as accepted so packet framing stays intact.
  assign accept = data_in_valid && data_in_ready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (data_in_tlast)          state_d = IDLE;
      else if (state_q == IDLE)   state_d = (target_class == CLASS_HP) ? IN_HP : IN_LP;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  stream_class_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_hp_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (store && (target_class == CLASS_HP)),
    .data_i  (data_in),
    .tlast_i (data_in_tlast),
    .pop_i   (data_out_hp_ready),
    .data_o  (data_out_hp),
    .tlast_o (data_out_hp_tlast),
    .valid_o (data_out_hp_valid),
    .full_o  (hp_full),
    .fill_o  (hp_fill_level)
  );

  stream_class_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_lp_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (store && (target_class == CLASS_LP)),
    .data_i  (data_in),
    .tlast_i (data_in_tlast),
    .pop_i   (data_out_lp_ready),
    .data_o  (data_out_lp),
    .tlast_o (data_out_lp_tlast),
    .valid_o (data_out_lp_valid),
    .full_o  (lp_full),
    .fill_o  (lp_fill_level)
  );

endmodule

`default_nettype wire

// File: tb/tb_priority_stream_splitter.sv
// +----------------------------------------------------------------------------+
// | tb_priority_stream_splitter: directed self-checking bench for the splitter  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_priority_stream_splitter;

  localparam int DW = 32;
  localparam int FD = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_tlast = 1'b0;
  logic          data_in_prio = 1'b0;
  logic          data_in_ready;
  logic [DW-1:0] data_out_hp;
  logic          data_out_hp_valid;
  logic          data_out_hp_tlast;
  logic          data_out_hp_ready = 1'b0;
  logic [DW-1:0] data_out_lp;
  logic          data_out_lp_valid;
  logic          data_out_lp_tlast;
  logic          data_out_lp_ready = 1'b0;
  logic [4:0]    hp_fill_level;
  logic [4:0]    lp_fill_level;
`ifdef PRIORITY_STREAM_SPLITTER_DROP_EN
  logic [15:0]   drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  priority_stream_splitter #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .data_in           (data_in),
    .data_in_valid     (data_in_valid),
    .data_in_tlast     (data_in_tlast),
    .data_in_prio      (data_in_prio),
    .data_in_ready     (data_in_ready),
    .data_out_hp       (data_out_hp),
    .data_out_hp_valid (data_out_hp_valid),
    .data_out_hp_tlast (data_out_hp_tlast),
    .data_out_hp_ready (data_out_hp_ready),
    .data_out_lp       (data_out_lp),
    .data_out_lp_valid (data_out_lp_valid),
    .data_out_lp_tlast (data_out_lp_tlast),
    .data_out_lp_ready (data_out_lp_ready),
    .hp_fill_level     (hp_fill_level),
    .lp_fill_level     (lp_fill_level)
`ifdef PRIORITY_STREAM_SPLITTER_DROP_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic prio, input logic last);
    data_in       = d;
    data_in_prio  = prio;
    data_in_tlast = last;
    data_in_valid = 1'b1;
    check_eq("in_ready", 32'(data_in_ready), 32'd1);
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic pop_hp(input logic [31:0] d, input logic last);
    check_eq("hp_valid", 32'(data_out_hp_valid), 32'd1);
    check_eq("hp_data", data_out_hp, d);
    check_eq("hp_tlast", 32'(data_out_hp_tlast), 32'(last));
    data_out_hp_ready = 1'b1;
    step();
    data_out_hp_ready = 1'b0;
  endtask

  task automatic pop_lp(input logic [31:0] d, input logic last);
    check_eq("lp_valid", 32'(data_out_lp_valid), 32'd1);
    check_eq("lp_data", data_out_lp, d);
    check_eq("lp_tlast", 32'(data_out_lp_tlast), 32'(last));
    data_out_lp_ready = 1'b1;
    step();
    data_out_lp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) step();
    check_eq("rst_hp_valid", 32'(data_out_hp_valid), 32'd0);
    check_eq("rst_lp_valid", 32'(data_out_lp_valid), 32'd0);
    check_eq("rst_hp_fill", 32'(hp_fill_level), 32'd0);
    check_eq("rst_lp_fill", 32'(lp_fill_level), 32'd0);
    check_eq("rst_hp_data", data_out_hp, 32'd0);
    check_eq("rst_lp_tlast", 32'(data_out_lp_tlast), 32'd0);
`ifdef PRIORITY_STREAM_SPLITTER_DROP_EN
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    reset = 1'b1;
    step();
    check_eq("post_rst_ready", 32'(data_in_ready), 32'd1);

    // Routing: two-beat HP packet then single-beat LP packet.
    send_beat(32'h11, 1'b1, 1'b0);
    check_eq("latency_hp_valid", 32'(data_out_hp_valid), 32'd1);
    check_eq("latency_hp_data", data_out_hp, 32'h11);
    send_beat(32'h12, 1'b1, 1'b1);
    send_beat(32'h21, 1'b0, 1'b1);
    check_eq("route_hp_fill", 32'(hp_fill_level), 32'd2);
    check_eq("route_lp_fill", 32'(lp_fill_level), 32'd1);
    step();
    check_eq("stall_hp_data", data_out_hp, 32'h11);
    pop_hp(32'h11, 1'b0);
    pop_hp(32'h12, 1'b1);
    check_eq("route_hp_empty", 32'(data_out_hp_valid), 32'd0);
    pop_lp(32'h21, 1'b1);
    check_eq("route_lp_empty", 32'(data_out_lp_valid), 32'd0);

    // Class latching: prio toggles after the first beat.
    send_beat(32'h31, 1'b1, 1'b0);
    send_beat(32'h32, 1'b0, 1'b0);
    send_beat(32'h33, 1'b0, 1'b1);
    check_eq("latch_hp_fill", 32'(hp_fill_level), 32'd3);
    check_eq("latch_lp_fill", 32'(lp_fill_level), 32'd0);
    check_eq("latch_lp_valid", 32'(data_out_lp_valid), 32'd0);
    pop_hp(32'h31, 1'b0);
    pop_hp(32'h32, 1'b0);
    pop_hp(32'h33, 1'b1);

`ifndef PRIORITY_STREAM_SPLITTER_DROP_EN
    // HP full with backpressure; LP still flows.
    for (int i = 0; i < 16; i++) send_beat(32'h100 + 32'(i), 1'b1, 1'b0);
    check_eq("full_hp_fill", 32'(hp_fill_level), 32'd16);
    check_eq("full_in_ready", 32'(data_in_ready), 32'd0);
    data_in = 32'h110; data_in_prio = 1'b0; data_in_tlast = 1'b1; data_in_valid = 1'b1;
    step();
    check_eq("full_hold_fill", 32'(hp_fill_level), 32'd16);
    data_out_hp_ready = 1'b1;
    #1;
    check_eq("no_same_cycle_release", 32'(data_in_ready), 32'd0);
    step();
    data_out_hp_ready = 1'b0;
    check_eq("after_pop_fill", 32'(hp_fill_level), 32'd15);
    check_eq("after_pop_ready", 32'(data_in_ready), 32'd1);
    step();
    data_in_valid = 1'b0;
    check_eq("refill_hp_fill", 32'(hp_fill_level), 32'd16);
    send_beat(32'h77, 1'b0, 1'b1);
    check_eq("lp_flow_hp_fill", 32'(hp_fill_level), 32'd16);
    pop_lp(32'h77, 1'b1);
    for (int i = 1; i < 16; i++) pop_hp(32'h100 + 32'(i), 1'b0);
    pop_hp(32'h110, 1'b1);
    check_eq("full_drained", 32'(data_out_hp_valid), 32'd0);
`endif

    // Wrap-around with the HP output always ready.
    data_out_hp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = 32'(i); data_in_prio = 1'b1; data_in_tlast = 1'b1; data_in_valid = 1'b1;
      step();
      check_eq("wrap_data", data_out_hp, 32'(i));
      check_eq("wrap_fill_le2", 32'(hp_fill_level <= 5'd2), 32'd1);
    end
    data_in_valid = 1'b0;
    step();
    data_out_hp_ready = 1'b0;
    check_eq("wrap_empty", 32'(data_out_hp_valid), 32'd0);

    // Reset in the middle of a four-beat HP packet.
    send_beat(32'h41, 1'b1, 1'b0);
    send_beat(32'h42, 1'b1, 1'b0);
    reset = 1'b0;
    step();
    check_eq("mid_rst_hp_valid", 32'(data_out_hp_valid), 32'd0);
    check_eq("mid_rst_lp_valid", 32'(data_out_lp_valid), 32'd0);
    check_eq("mid_rst_hp_fill", 32'(hp_fill_level), 32'd0);
    check_eq("mid_rst_lp_fill", 32'(lp_fill_level), 32'd0);
    reset = 1'b1;
    send_beat(32'h55, 1'b0, 1'b1);
    check_eq("post_rst_lp_fill", 32'(lp_fill_level), 32'd1);
    check_eq("post_rst_hp_fill", 32'(hp_fill_level), 32'd0);
    pop_lp(32'h55, 1'b1);

`ifdef PRIORITY_STREAM_SPLITTER_DROP_EN
    // Drop mode: LP full, three extra beats discarded.
    for (int i = 0; i < 16; i++) send_beat(32'h200 + 32'(i), 1'b0, 1'b1);
    check_eq("drop_lp_fill", 32'(lp_fill_level), 32'd16);
    for (int k = 0; k < 3; k++) send_beat(32'hDEAD0 + 32'(k), 1'b0, 1'b1);
    check_eq("drop_count", 32'(drop_count), 32'd3);
    check_eq("drop_lp_fill_after", 32'(lp_fill_level), 32'd16);
    for (int i = 0; i < 16; i++) pop_lp(32'h200 + 32'(i), 1'b1);
    check_eq("drop_drained", 32'(data_out_lp_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
